// File: rtl/exec_cluster.sv
// Execute stage: N_ALU registered single-cycle ALU lanes plus a shift-add multiplier lane.
// ALU results one edge after issue with no back-pressure; the multiplier holds its product until mul_res_rdy.
module exec_cluster #(
  parameter int N_ALU  = 2,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int IMM_W  = 5,
  localparam int OPW   = DATA_W + TAG_W,
  localparam int RW    = DATA_W + 2 * TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_ALU-1:0]         alu_valid,
  input  logic [N_ALU*OPW-1:0]     alu_a,
  input  logic [N_ALU*OPW-1:0]     alu_b,
  input  logic [N_ALU*IMM_W-1:0]   alu_imm,
  input  logic [N_ALU-1:0]         alu_imm_sel,
  input  logic [N_ALU*4-1:0]       alu_op,
  input  logic [N_ALU*TAG_W-1:0]   alu_rd,
  output logic [N_ALU-1:0]         alu_res_vld,
  output logic [N_ALU*RW-1:0]      alu_res,
  output logic [N_ALU*TAG_W-1:0]   alu_rd_out,
  input  logic                     mul_in_vld,
  output logic                     mul_in_rdy,
  input  logic [OPW-1:0]           mul_a,
  input  logic [OPW-1:0]           mul_b,
  input  logic [IMM_W-1:0]         mul_imm,
  input  logic                     mul_imm_sel,
  input  logic [TAG_W-1:0]         mul_rd,
  output logic                     mul_res_vld,
  input  logic                     mul_res_rdy,
  output logic [RW-1:0]            mul_res,
  output logic [TAG_W-1:0]         mul_rd_out
);

  localparam int CW = $clog2(DATA_W + 1);

  for (genvar i = 0; i < N_ALU; i++) begin : g_lane
    logic [DATA_W-1:0] a_dat, b_dat, r_d;
    logic [TAG_W-1:0]  a_tag, b_tag;
    logic [3:0]        shamt, op;
    logic              vld_q;
    logic [RW-1:0]     res_q;
    logic [TAG_W-1:0]  rd_q;

    assign a_dat = alu_a[i*OPW+TAG_W +: DATA_W];
    assign a_tag = alu_a[i*OPW +: TAG_W];
    assign b_dat = alu_imm_sel[i] ? DATA_W'(alu_imm[i*IMM_W +: IMM_W])
                                  : alu_b[i*OPW+TAG_W +: DATA_W];
    assign b_tag = alu_imm_sel[i] ? '0 : alu_b[i*OPW +: TAG_W];
    assign shamt = b_dat[3:0];
    assign op    = alu_op[i*4 +: 4];

    always_comb begin
      r_d = '0;
      case (op)
        4'd0:    r_d = a_dat + b_dat;
        4'd1:    r_d = a_dat - b_dat;
        4'd2:    r_d = a_dat & b_dat;
        4'd3:    r_d = a_dat | b_dat;
        4'd4:    r_d = a_dat ^ b_dat;
        4'd5:    r_d = a_dat << shamt;
        4'd6:    r_d = a_dat >> shamt;
        4'd7:    r_d = $signed(a_dat) >>> shamt;
        default: r_d = '0;
      endcase
    end

    // Flush drops this cycle's issue; result data is only refreshed on a real issue.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        res_q <= '0;
        rd_q  <= '0;
      end else begin
        vld_q <= alu_valid[i] && !flush;
        if (alu_valid[i] && !flush) begin
          res_q <= {r_d, b_tag, a_tag};
          rd_q  <= alu_rd[i*TAG_W +: TAG_W];
        end
      end
    end

    assign alu_res_vld[i]               = vld_q;
    assign alu_res[i*RW +: RW]          = res_q;
    assign alu_rd_out[i*TAG_W +: TAG_W] = rd_q;
  end

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mul_state_e;

  mul_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]  ta_q, ta_d, tb_q, tb_d, rd_q, rd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    ta_d    = ta_q;
    tb_d    = tb_q;
    rd_d    = rd_q;
    case (state_q)
      M_IDLE: begin
        if (mul_in_vld && !flush) begin
          state_d = M_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          a_d     = mul_a[OPW-1:TAG_W];
          b_d     = mul_imm_sel ? DATA_W'(mul_imm) : mul_b[OPW-1:TAG_W];
          ta_d    = mul_a[TAG_W-1:0];
          tb_d    = mul_imm_sel ? '0 : mul_b[TAG_W-1:0];
          rd_d    = mul_rd;
        end
      end
      M_RUN: begin
        // A shifts up and B shifts down so bit cnt of B is always at B[0].
        if (cnt_q == CW'(DATA_W)) begin
          state_d = M_DONE;
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      M_DONE: begin
        if (mul_res_rdy) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
    if (flush) state_d = M_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= M_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      rd_q    <= rd_d;
    end
  end

  assign mul_in_rdy  = (state_q == M_IDLE) && !rst;
  assign mul_res_vld = (state_q == M_DONE);
  assign mul_res     = {acc_q, tb_q, ta_q};
  assign mul_rd_out  = rd_q;

endmodule

// File: tb/tb_exec_cluster.sv
// Randomised bench for exec_cluster against an arithmetic reference model.
module tb_exec_cluster;
  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int TW  = 5;
  localparam int IW  = 5;
  localparam int OPW = DW + TW;
  localparam int RW  = DW + 2 * TW;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [N-1:0]      alu_valid, alu_imm_sel, alu_res_vld;
  logic [N*OPW-1:0]  alu_a, alu_b;
  logic [N*IW-1:0]   alu_imm;
  logic [N*4-1:0]    alu_op;
  logic [N*TW-1:0]   alu_rd, alu_rd_out;
  logic [N*RW-1:0]   alu_res;
  logic              mul_in_vld, mul_in_rdy, mul_imm_sel, mul_res_vld, mul_res_rdy;
  logic [OPW-1:0]    mul_a, mul_b;
  logic [IW-1:0]     mul_imm;
  logic [TW-1:0]     mul_rd, mul_rd_out;
  logic [RW-1:0]     mul_res;

  int n_vec = 0;
  int n_err = 0;

  exec_cluster #(.N_ALU(N), .DATA_W(DW), .TAG_W(TW), .IMM_W(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_imm_sel(alu_imm_sel), .alu_op(alu_op), .alu_rd(alu_rd),
    .alu_res_vld(alu_res_vld), .alu_res(alu_res), .alu_rd_out(alu_rd_out),
    .mul_in_vld(mul_in_vld), .mul_in_rdy(mul_in_rdy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_imm(mul_imm), .mul_imm_sel(mul_imm_sel), .mul_rd(mul_rd),
    .mul_res_vld(mul_res_vld), .mul_res_rdy(mul_res_rdy), .mul_res(mul_res),
    .mul_rd_out(mul_rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] alu_ref(input int op, input int a, input int b);
    int sh, s, r;
    sh = b % 16;
    s  = (a >= 32768) ? a - 65536 : a;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * (2 ** sh);
      6: r = a / (2 ** sh);
      7: r = s >>> sh;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic set_alu(input int l, input bit v, input int op, input logic [15:0] a,
                         input logic [4:0] ta, input logic [15:0] b, input logic [4:0] tb_,
                         input logic [4:0] imm, input bit sel, input logic [4:0] rd);
    alu_valid[l]          = v;
    alu_op[l*4 +: 4]      = op[3:0];
    alu_a[l*OPW +: OPW]   = {a, ta};
    alu_b[l*OPW +: OPW]   = {b, tb_};
    alu_imm[l*IW +: IW]   = imm;
    alu_imm_sel[l]        = sel;
    alu_rd[l*TW +: TW]    = rd;
  endtask

  // Issues one multiply, checks latency, product, tags and the hold/release behaviour.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] imm,
                        input bit sel, input int hold);
    logic [4:0]  ta, tbv, rd;
    logic [15:0] bb, prod;
    int lat, w;
    ta = 5'($urandom); tbv = 5'($urandom); rd = 5'($urandom);
    bb   = sel ? {11'd0, imm} : b;
    prod = 16'(int'(a) * int'(bb));
    w = 0;
    while (!mul_in_rdy && w < 50) begin tick(); w++; end
    chk("mul_in_rdy_wait", mul_in_rdy, 1);
    mul_a = {a, ta}; mul_b = {b, tbv}; mul_imm = imm; mul_imm_sel = sel; mul_rd = rd;
    mul_in_vld = 1'b1; mul_res_rdy = (hold == 0);
    tick();
    mul_in_vld = 1'b0;
    mul_a = '0; mul_b = '0; mul_rd = '0;
    lat = 0;
    while (!mul_res_vld && lat < 40) begin
      chk("mul_rdy_busy", mul_in_rdy, 0);
      tick(); lat++;
    end
    chk("mul_latency", lat, 17);
    for (int k = 0; k < hold; k++) begin
      chk("mul_hold_vld", mul_res_vld, 1);
      chk("mul_hold_res", mul_res, {prod, sel ? 5'd0 : tbv, ta});
      chk("mul_hold_rdy", mul_in_rdy, 0);
      tick();
    end
    mul_res_rdy = 1'b1;
    chk("mul_vld", mul_res_vld, 1);
    chk("mul_res", mul_res, {prod, sel ? 5'd0 : tbv, ta});
    chk("mul_rd", mul_rd_out, rd);
    tick();
    mul_res_rdy = 1'b0;
    chk("mul_vld_drop", mul_res_vld, 0);
    chk("mul_rdy_back", mul_in_rdy, 1);
  endtask

  initial begin
    bit          ev [N];
    logic [RW-1:0] er [N];
    logic [TW-1:0] ed [N];

    rst = 1'b1; flush = 1'b0;
    alu_valid = '0; alu_a = '0; alu_b = '0; alu_imm = '0; alu_imm_sel = '0; alu_op = '0; alu_rd = '0;
    mul_in_vld = 1'b0; mul_a = '0; mul_b = '0; mul_imm = '0; mul_imm_sel = 1'b0; mul_rd = '0;
    mul_res_rdy = 1'b0;
    tick(); tick();
    chk("rst_alu_vld", alu_res_vld, 0);
    chk("rst_alu_res", alu_res, 0);
    chk("rst_alu_rd", alu_rd_out, 0);
    chk("rst_mul_vld", mul_res_vld, 0);
    chk("rst_mul_res", mul_res, 0);
    chk("rst_mul_rd", mul_rd_out, 0);
    chk("rst_in_rdy", mul_in_rdy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_rdy", mul_in_rdy, 1);

    // Directed ALU: wrap-around add on lane 0, immediate subtract on lane 1.
    set_alu(0, 1, 0, 16'hFFFF, 5'd3, 16'h0001, 5'd7, 5'd0, 0, 5'd12);
    set_alu(1, 1, 1, 16'h0010, 5'd4, 16'h1234, 5'd9, 5'd5, 1, 5'd21);
    tick();
    alu_valid = '0;
    chk("add_vld", alu_res_vld, 2'b11);
    chk("add_res", alu_res[0 +: RW], {16'h0000, 5'd7, 5'd3});
    chk("add_rd", alu_rd_out[0 +: TW], 12);
    chk("imm_res", alu_res[RW +: RW], {16'h000B, 5'd0, 5'd4});
    chk("imm_rd", alu_rd_out[TW +: TW], 21);
    tick();
    chk("idle_vld", alu_res_vld, 0);

    do_mul(16'h0123, 16'h0010, 5'd0, 0, 0);
    do_mul(16'h00FF, 16'h00FF, 5'd0, 0, 5);

    // Flush at cnt=8 with a lane-0 issue in the same cycle.
    mul_a = {16'h1234, 5'd1}; mul_b = {16'h0FFF, 5'd2}; mul_in_vld = 1'b1;
    tick();
    mul_in_vld = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    flush = 1'b1;
    set_alu(0, 1, 0, 16'h0001, 5'd1, 16'h0001, 5'd1, 5'd0, 0, 5'd1);
    tick();
    flush = 1'b0; alu_valid = '0;
    chk("flush_alu_vld", alu_res_vld, 0);
    chk("flush_mul_vld", mul_res_vld, 0);
    chk("flush_idle", mul_in_rdy, 1);
    do_mul(16'h0BCD, 16'h0003, 5'd0, 0, 1);

    // Flush beats a request presented in IDLE.
    flush = 1'b1; mul_in_vld = 1'b1;
    tick();
    flush = 1'b0; mul_in_vld = 1'b0;
    chk("flush_drop_req", mul_in_rdy, 1);

    // Reset mid-multiply loses the result.
    mul_a = {16'h0007, 5'd1}; mul_b = {16'h0009, 5'd2}; mul_in_vld = 1'b1;
    tick();
    mul_in_vld = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("rst_mid_vld", mul_res_vld, 0);
      tick();
    end

    // Random ALU traffic with occasional flush.
    for (int i = 0; i < N; i++) ev[i] = 0;
    for (int c = 0; c < 300; c++) begin
      bit fl;
      fl = ($urandom_range(0, 15) == 0);
      flush = fl;
      for (int l = 0; l < N; l++) begin
        int op, a, b, imm;
        bit v, sel;
        logic [4:0] ta, tbv, rd;
        v = $urandom_range(0, 3) != 0; op = $urandom_range(0, 15);
        a = $urandom_range(0, 65535); b = $urandom_range(0, 65535);
        imm = $urandom_range(0, 31); sel = $urandom_range(0, 1);
        ta = 5'($urandom); tbv = 5'($urandom); rd = 5'($urandom);
        set_alu(l, v, op, 16'(a), ta, 16'(b), tbv, 5'(imm), sel, rd);
        ev[l] = v && !fl;
        if (ev[l]) begin
          er[l] = {alu_ref(op, a, sel ? imm : b), sel ? 5'd0 : tbv, ta};
          ed[l] = rd;
        end
      end
      tick();
      for (int l = 0; l < N; l++) begin
        chk("rnd_vld", alu_res_vld[l], ev[l]);
        if (ev[l]) begin
          chk("rnd_res", alu_res[l*RW +: RW], er[l]);
          chk("rnd_rd", alu_rd_out[l*TW +: TW], ed[l]);
        end
      end
    end
    flush = 1'b0; alu_valid = '0;

    // Random multiplies with random write-back stalls.
    for (int m = 0; m < 20; m++) begin
      do_mul(16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
